// File: rtl/i2c_target_regfile.sv
// I2C target with a DEPTH-byte register file, register pointer with auto-increment,
// repeated START support and NACK on address mismatch. SCL/SDA are oversampled on clk.
module i2c_target_regfile #(
   parameter logic [6:0]  ADDR        = 7'b1101111,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned PW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic          lcl_we,
   input  logic [PW-1:0] lcl_idx,
   input  logic [7:0]    lcl_wdata,
   output logic [7:0]    lcl_rdata,
   output logic          wr_strobe,
   output logic [PW-1:0] wr_idx,
   output logic [7:0]    wr_data,
   output logic          busy
);

   localparam int unsigned CW = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ACK_A,
      S_PTR,
      S_ACK_P,
      S_WDATA,
      S_ACK_W,
      S_RDATA,
      S_RACK,
      S_RLOAD,
      S_WAIT_STOP
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise_c, scl_fall_c, start_c, stop_c;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sh_q, sh_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          rw_q, rw_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_strobe_q, wr_strobe_d;
   logic [PW-1:0] wr_idx_q, wr_idx_d;
   logic [7:0]    wr_data_q, wr_data_d;

   logic [7:0]    regs_q [DEPTH];
   logic [7:0]    rx_byte_c;
   logic [7:0]    rd_byte_c;
   logic          last_bit_c;
   logic          commit_c;

   // Synchroniser and history flops free-run through reset so that edges seen
   // after reset reflect genuine bus activity rather than reset artefacts.
   always_ff @(posedge clk) begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
   end

   // Bus event decode from the synchronised lines.
   always_comb begin
      scl_s      = scl_sync_q[SYNC_STAGES-1];
      sda_s      = sda_sync_q[SYNC_STAGES-1];
      scl_rise_c = scl_s & ~scl_prev_q;
      scl_fall_c = ~scl_s & scl_prev_q;
      start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      rx_byte_c  = {sh_q[6:0], sda_s};
      last_bit_c = (cnt_q == CW'(7));
      rd_byte_c  = regs_q[ptr_q];
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_idx_q    <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_idx_q    <= wr_idx_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Next-state logic; ACK states use sda_oe_q to tell the driving half from the release half.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_idx_d    = wr_idx_q;
      wr_data_d   = wr_data_q;
      commit_c    = 1'b0;

      if (start_c) begin
         state_d  = S_ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
      end else if (stop_c) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end
            S_ADDR: begin
               if (scl_rise_c) begin
                  sh_d  = rx_byte_c;
                  cnt_d = cnt_q + CW'(1);
                  if (last_bit_c) begin
                     cnt_d = '0;
                     if (rx_byte_c[7:1] == ADDR) begin
                        rw_d    = rx_byte_c[0];
                        busy_d  = 1'b1;
                        state_d = S_ACK_A;
                     end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                     end
                  end
               end
            end
            S_ACK_A: begin
               if (scl_fall_c) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q) begin
                     sh_d     = {rd_byte_c[6:0], 1'b0};
                     sda_oe_d = ~rd_byte_c[7];
                     cnt_d    = CW'(1);
                     state_d  = S_RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_PTR;
                  end
               end
            end
            S_PTR: begin
               if (scl_rise_c) begin
                  sh_d  = rx_byte_c;
                  cnt_d = cnt_q + CW'(1);
                  if (last_bit_c) begin
                     cnt_d   = '0;
                     ptr_d   = rx_byte_c[PW-1:0];
                     state_d = S_ACK_P;
                  end
               end
            end
            S_ACK_P, S_ACK_W: begin
               if (scl_fall_c) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               if (scl_rise_c) begin
                  sh_d  = rx_byte_c;
                  cnt_d = cnt_q + CW'(1);
                  if (last_bit_c) begin
                     cnt_d       = '0;
                     commit_c    = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_idx_d    = ptr_q;
                     wr_data_d   = rx_byte_c;
                     ptr_d       = ptr_q + PW'(1);
                     state_d     = S_ACK_W;
                  end
               end
            end
            S_RDATA: begin
               if (scl_fall_c) begin
                  if (cnt_q == CW'(8)) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = S_RACK;
                  end else begin
                     sda_oe_d = ~sh_q[7];
                     sh_d     = {sh_q[6:0], 1'b0};
                     cnt_d    = cnt_q + CW'(1);
                  end
               end
            end
            S_RACK: begin
               if (scl_rise_c) begin
                  ptr_d   = ptr_q + PW'(1);
                  state_d = sda_s ? S_WAIT_STOP : S_RLOAD;
               end
            end
            S_RLOAD: begin
               if (scl_fall_c) begin
                  sh_d     = {rd_byte_c[6:0], 1'b0};
                  sda_oe_d = ~rd_byte_c[7];
                  cnt_d    = CW'(1);
                  state_d  = S_RDATA;
               end
            end
            S_WAIT_STOP: begin
            end
            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Register file: local write first, a same-cycle bus commit overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (lcl_we) begin
            regs_q[lcl_idx] <= lcl_wdata;
         end
         if (commit_c) begin
            regs_q[ptr_q] <= rx_byte_c;
         end
      end
   end

   assign lcl_rdata = regs_q[lcl_idx];
   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_idx    = wr_idx_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master with open-drain SDA model.
module tb_i2c_target_regfile;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 4;
   localparam int unsigned Q     = 5;   // clk cycles per quarter SCL period

   logic          clk = 1'b0;
   logic          rst;
   logic          scl_m, sda_m;
   logic          sda_line;
   logic          sda_oe;
   logic          lcl_we;
   logic [PW-1:0] lcl_idx;
   logic [7:0]    lcl_wdata;
   logic [7:0]    lcl_rdata;
   logic          wr_strobe;
   logic [PW-1:0] wr_idx;
   logic [7:0]    wr_data;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int strobe_cnt = 0;
   int oe_cnt = 0;
   logic [PW-1:0] idx_log [64];
   logic [7:0]    dat_log [64];

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_regfile #(.ADDR(7'b1101111), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .lcl_we    (lcl_we),
      .lcl_idx   (lcl_idx),
      .lcl_wdata (lcl_wdata),
      .lcl_rdata (lcl_rdata),
      .wr_strobe (wr_strobe),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   // Log every committed byte and count cycles with SDA pulled.
   always @(posedge clk) begin
      if (wr_strobe && strobe_cnt < 64) begin
         idx_log[strobe_cnt] <= wr_idx;
         dat_log[strobe_cnt] <= wr_data;
         strobe_cnt <= strobe_cnt + 1;
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic rd_reg(input int idx, output int val);
      lcl_idx = PW'(idx);
      #1;
      val = int'(lcl_rdata);
   endtask

   task automatic lcl_write(input int idx, input int val);
      @(negedge clk);
      lcl_idx   = PW'(idx);
      lcl_wdata = 8'(val);
      lcl_we    = 1'b1;
      @(negedge clk);
      lcl_we    = 1'b0;
   endtask

   // START from idle or as repeated START (SCL low, SDA released).
   task automatic i2c_start();
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      sda_m = 1'b0; qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; qwait();
      scl_m = 1'b1; qwait();
      sda_m = 1'b1; qwait();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    qwait();
      scl_m = 1'b1; qwait(); qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      b = sda_line; qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(r);
      ack = ~r;
   endtask

   task automatic recv_byte(output logic [7:0] v, input logic nack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(r);
         v[i] = r;
      end
      send_bit(nack);
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      int         v;
      int         oe0;

      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      lcl_we = 1'b0; lcl_idx = '0; lcl_wdata = '0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state
      check("rst_sda_oe", int'(sda_oe), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_wr_strobe", int'(wr_strobe), 0);
      check("rst_wr_idx", int'(wr_idx), 0);
      check("rst_wr_data", int'(wr_data), 0);
      rd_reg(0, v); check("rst_reg0", v, 0);

      // Write 0x06 to reg[3]
      i2c_start();
      send_byte(8'hDE, ack); check("w1_ack_addr", int'(ack), 1);
      check("w1_busy", int'(busy), 1);
      send_byte(8'h03, ack); check("w1_ack_ptr", int'(ack), 1);
      send_byte(8'h06, ack); check("w1_ack_data", int'(ack), 1);
      i2c_stop(); qwait();
      check("w1_busy_after", int'(busy), 0);
      check("w1_strobes", strobe_cnt, 1);
      check("w1_idx", int'(idx_log[0]), 3);
      check("w1_data", int'(dat_log[0]), 8'h06);
      rd_reg(3, v); check("w1_reg3", v, 8'h06);

      // Address mismatch
      oe0 = oe_cnt;
      i2c_start();
      send_byte(8'hA0, ack); check("nm_ack_addr", int'(ack), 0);
      send_byte(8'h55, ack); check("nm_ack_data", int'(ack), 0);
      check("nm_busy", int'(busy), 0);
      i2c_stop(); qwait();
      check("nm_oe_cycles", oe_cnt - oe0, 0);
      check("nm_strobes", strobe_cnt, 1);
      rd_reg(3, v); check("nm_reg3", v, 8'h06);
      rd_reg(5, v); check("nm_reg5", v, 0);

      // Pointer wrap at DEPTH-1
      i2c_start();
      send_byte(8'hDE, ack);
      send_byte(8'h0F, ack);
      send_byte(8'h11, ack); check("wr_ack_b1", int'(ack), 1);
      send_byte(8'h22, ack); check("wr_ack_b2", int'(ack), 1);
      i2c_stop(); qwait();
      check("wr_strobes", strobe_cnt, 3);
      check("wr_idx_a", int'(idx_log[1]), 15);
      check("wr_dat_a", int'(dat_log[1]), 8'h11);
      check("wr_idx_b", int'(idx_log[2]), 0);
      check("wr_dat_b", int'(dat_log[2]), 8'h22);
      rd_reg(15, v); check("wr_reg15", v, 8'h11);
      rd_reg(0, v);  check("wr_reg0", v, 8'h22);

      // Combined write-pointer / repeated-START read
      lcl_write(5, 8'hA5);
      lcl_write(6, 8'h3C);
      i2c_start();
      send_byte(8'hDE, ack);
      send_byte(8'h05, ack); check("rd_ack_ptr", int'(ack), 1);
      i2c_start();
      send_byte(8'hDF, ack); check("rd_ack_addr", int'(ack), 1);
      recv_byte(d, 1'b0); check("rd_byte1", int'(d), 8'hA5);
      recv_byte(d, 1'b1); check("rd_byte2", int'(d), 8'h3C);
      check("rd_busy_wait", int'(busy), 1);
      check("rd_released", int'(sda_oe), 0);
      i2c_stop(); qwait();
      check("rd_busy_after", int'(busy), 0);

      // Aborted partial data byte
      i2c_start();
      send_byte(8'hDE, ack);
      send_byte(8'h02, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop(); qwait();
      check("ab_strobes", strobe_cnt, 3);
      rd_reg(2, v); check("ab_reg2", v, 0);
      i2c_start();
      send_byte(8'hDE, ack); check("ab_next_ack", int'(ack), 1);
      send_byte(8'h02, ack);
      send_byte(8'h77, ack); check("ab_next_data", int'(ack), 1);
      i2c_stop(); qwait();
      check("ab_next_strobes", strobe_cnt, 4);
      rd_reg(2, v); check("ab_reg2_new", v, 8'h77);

      // Bus commit and local write to the same index in the same cycle
      i2c_start();
      send_byte(8'hDE, ack);
      send_byte(8'h09, ack);
      d = 8'h5A;
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      sda_m = d[0]; qwait();
      scl_m = 1'b1;
      @(negedge clk); @(negedge clk);
      lcl_idx = PW'(9); lcl_wdata = 8'hC3; lcl_we = 1'b1;
      @(negedge clk);
      lcl_we = 1'b0;
      qwait();
      scl_m = 1'b0; qwait();
      recv_bit(b); check("col_ack", int'(b), 0);
      i2c_stop(); qwait();
      check("col_strobes", strobe_cnt, 5);
      check("col_idx", int'(idx_log[4]), 9);
      rd_reg(9, v); check("col_reg9", v, 8'h5A);

      // Reset in the middle of a read
      i2c_start();
      send_byte(8'hDE, ack);
      send_byte(8'h07, ack);
      i2c_start();
      send_byte(8'hDF, ack);
      recv_bit(b); check("rr_bit7", int'(b), 0);
      repeat (4) @(negedge clk);
      check("rr_oe_before", int'(sda_oe), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rr_oe_after", int'(sda_oe), 0);
      check("rr_busy_after", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      oe0 = oe_cnt;
      for (int i = 0; i < 6; i++) recv_bit(b);
      send_bit(1'b1);
      i2c_stop(); qwait();
      check("rr_ignored", oe_cnt - oe0, 0);
      check("rr_wr_data", int'(wr_data), 0);
      rd_reg(9, v); check("rr_reg9_clr", v, 0);
      i2c_start();
      send_byte(8'hDE, ack); check("rr_fresh_ack", int'(ack), 1);
      send_byte(8'h04, ack);
      send_byte(8'h99, ack);
      i2c_stop(); qwait();
      rd_reg(4, v); check("rr_reg4", v, 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synchronous, parametrised I2C target. Supersedes the edge-clocked slave: all logic runs on one system clock, and SCL/SDA are oversampled.
- Supports write and read transfers, a register pointer, a DEPTH-byte register file with auto-increment, repeated START, and NACK on address mismatch.
- Sits between the open-drain pad wrapper (scl_i/sda_i/sda_oe) and local logic, which sees the register file through a side port.

Parameters:
- ADDR, 7'b1101111, 7-bit target address.
- DEPTH, 16, number of byte registers; power of 2, 2..256.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (minimum 2).
- PW, $clog2(DEPTH), pointer width (derived; not for override).

Ports:
- clk  in  1  system clock; at least 8x SCL rate.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pad input, asynchronous.
- sda_i  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- lcl_we  in  1  local register write strobe.
- lcl_idx  in  PW  local write/read index.
- lcl_wdata  in  8  local write data.
- lcl_rdata  out  8  reg[lcl_idx], combinational.
- wr_strobe  out  1  1-cycle pulse when a bus data byte is committed.
- wr_idx  out  PW  index of committed byte.
- wr_data  out  8  committed byte.
- busy  out  1  high from addressed START until STOP/NACK-exit.

Behaviour:
- Reset values:
  - sda_oe=0, wr_strobe=0, wr_idx=0, wr_data=0, busy=0.
  - State=IDLE, pointer=0, bit counter=0.
  - Register file cleared to 0.
- Input conditioning:
  - scl_i and sda_i pass through SYNC_STAGES flops, then one history flop.
  - scl_rise/scl_fall are edges of the synchronised SCL.
  - START = synchronised SDA falls while SCL is high. STOP = SDA rises while SCL is high.
  - START/STOP take priority over bit sampling in the same cycle.
- Timing rules:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, never while SCL is high, except it is forced to 0 on STOP/reset.
- States:
  - IDLE: on START go to ADDR, bit counter=0.
  - ADDR: shift 8 bits MSB first. On the 8th bit, compare [7:1] to ADDR. On match, latch R/W and go to ACK_A (busy=1). On mismatch, go IDLE with sda_oe held 0 (NACK); ignore the bus until the next START.
  - ACK_A: drive sda_oe=1 for the ACK clock.
    - Write (R/W=0): next scl_fall goes to PTR.
    - Read (R/W=1): next scl_fall loads shift register = reg[pointer], drives bit 7, goes to RDATA.
  - PTR: shift 8 bits. pointer = byte mod DEPTH (upper bits ignored). Go to ACK_P, which ACKs and then goes to WDATA.
  - WDATA: shift 8 bits.
    - On the 8th scl_rise: reg[pointer] <= byte; wr_strobe pulses with wr_idx=pointer, wr_data=byte; pointer <= pointer+1 mod DEPTH (wraps DEPTH-1 -> 0).
    - Go to ACK_W, which ACKs and then returns to WDATA.
  - RDATA: shift out one bit per scl_fall (sda_oe = ~bit). After 8 bits, release on scl_fall and go to RACK.
  - RACK: sample master ACK on scl_rise; pointer <= pointer+1 mod DEPTH.
    - ACK (SDA=0): reload from reg[pointer] and continue RDATA.
    - NACK (SDA=1): go WAIT_STOP (released, busy held until STOP/START).
- Bus conditions in any state:
  - STOP: go IDLE, sda_oe=0, busy=0.
  - START (repeated): go ADDR, counter=0. Pointer is retained, so write-pointer-then-repeated-START-read works.
  - Partial byte aborted by START/STOP: discarded; no register write, no wr_strobe.
- Local port:
  - lcl_we writes reg[lcl_idx] in the next cycle.
  - If a bus commit targets the same index in the same cycle, the bus write wins.
  - A local write to a byte already loaded into the read shift register does not affect the byte in flight.
- Reset mid-transfer: immediate release of SDA, state IDLE; the target ignores the bus until a fresh START.

Test Plan:
- Write 0x06 to reg[3]: START, 0xDE, 0x03, 0x06, STOP -> ACK on all 3 bytes; wr_strobe once with wr_idx=3, wr_data=0x06; lcl_idx=3 reads 0x06; busy falls after STOP.
- Address mismatch: START, 0xA0, 0x55, STOP -> sda_oe stays 0 throughout; no wr_strobe; registers unchanged; busy=0.
- Wrap with DEPTH=16: write pointer 0x0F then bytes 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22; wr_idx sequence 15, 0.
- Combined read: lcl preload reg[5]=0xA5 and reg[6]=0x3C; START, 0xDE, 0x05, repeated START, 0xDF; master ACKs byte 1, NACKs byte 2 -> SDA shows 0xA5 then 0x3C; target releases and returns to IDLE at STOP.
- Abort: START, 0xDE, 0x02, 4 bits of data, STOP -> no wr_strobe; reg[2] unchanged; next transfer ACKs normally.
- Collision and reset: bus commit and lcl_we to the same idx in the same cycle -> bus value stored. rst asserted during RDATA -> sda_oe=0 the next cycle, state IDLE.
